// File: rtl/audio_mix_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module     : audio_pkg
// Description: Shared constants, state encoding and channel-to-side mapping
//              for the time-multiplexed four-channel audio mixer.
// Revision   : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int DW      = 8;   // channel sample width (signed)
    localparam int VW      = 7;   // channel volume width (unsigned, 0..64)
    localparam int OW      = 9;   // output sum width per side (signed)
    localparam int VOL_MAX = 64;  // full-scale volume
    localparam int ACC_W   = 16;  // accumulator width
    localparam int SHIFT   = 6;   // volume scaling (divide by 64)

    // Sequencer states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CH0  = 3'd1,
        ST_CH1  = 3'd2,
        ST_CH2  = 3'd3,
        ST_CH3  = 3'd4,
        ST_LOAD = 3'd5
    } mix_state_t;

    // Bit n set: channel n feeds the left accumulator (unswapped layout).
    localparam logic [3:0] CH_LEFT_MAP = 4'b1001;

    // Any volume with bit 6 set is treated as full scale (64).
    function automatic logic [VW-1:0] clamp_vol(input logic [VW-1:0] vol);
        logic [VW-1:0] eff;
        eff = vol[VW-1] ? VW'(VOL_MAX) : {1'b0, vol[VW-2:0]};
        return eff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_mix_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module     : audio_mix_sequencer_if
// Description: Channel inputs and mixed-sample outputs of the audio mixer.
//              master : audio source side (drives samples, volumes, tick)
//              slave  : mixer side (drives sums and status pulses)
// Revision   : 1.0 - initial release
// ============================================================================
interface audio_mix_sequencer_if;
    import audio_pkg::*;

    logic                 clk7_en;
    logic                 cck;
    logic signed [DW-1:0] aud0, aud1, aud2, aud3;
    logic        [VW-1:0] vol0, vol1, vol2, vol3;
    logic                 mute;
    logic signed [OW-1:0] ldatasum;
    logic signed [OW-1:0] rdatasum;
    logic                 sample_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output clk7_en, cck, aud0, aud1, aud2, aud3,
               vol0, vol1, vol2, vol3, mute,
        input  ldatasum, rdatasum, sample_valid, busy, overrun
    );

    modport slave (
        input  clk7_en, cck, aud0, aud1, aud2, aud3,
               vol0, vol1, vol2, vol3, mute,
        output ldatasum, rdatasum, sample_valid, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/audio_mix_sequencer_vol_mac.sv
`default_nettype none
// ============================================================================
// Module     : audio_mix_sequencer_vol_mac
// Description: Volume clamp, shared signed x unsigned multiplier and the two
//              side accumulators. Multiply is combinational; accumulators are
//              registered and cleared at the start of each sample.
// Ports      : clk, rst         - clock, synchronous active-high reset
//              i_clr            - clear both accumulators
//              i_en             - add current product this clock
//              i_to_left        - 1 = left accumulator, 0 = right
//              i_sample, i_vol  - current channel sample and raw volume
//              o_acc_l, o_acc_r - accumulated sums
// Revision   : 1.0 - initial release
// ============================================================================
module audio_mix_sequencer_vol_mac
    import audio_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_clr,
    input  wire logic                    i_en,
    input  wire logic                    i_to_left,
    input  wire logic signed [DW-1:0]    i_sample,
    input  wire logic        [VW-1:0]    i_vol,
    output logic      signed [ACC_W-1:0] o_acc_l,
    output logic      signed [ACC_W-1:0] o_acc_r
);

    logic        [VW-1:0]    w_eff_vol;
    logic signed [ACC_W-1:0] w_prod;

    // Volume is zero-extended so the multiply stays signed x unsigned.
    always_comb begin
        w_eff_vol = clamp_vol(i_vol);
        w_prod    = ACC_W'(i_sample) * ACC_W'($signed({1'b0, w_eff_vol}));
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_acc_l <= '0;
            o_acc_r <= '0;
        end else if (i_en) begin
            if (i_to_left) begin
                o_acc_l <= o_acc_l + w_prod;
            end else begin
                o_acc_r <= o_acc_r + w_prod;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_mix_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : audio_mix_sequencer
// Description: Four-channel volume/mix engine. On each sample tick the inputs
//              are snapshotted, four multiply-accumulate steps run one clock
//              each, and the scaled sums are loaded into ldatasum/rdatasum.
// Ports      : clk   - sole clock
//              reset - synchronous active-high reset
//              bus   - channel inputs / mixed outputs (slave modport)
// Revision   : 1.0 - initial release
// ============================================================================
module audio_mix_sequencer
    import audio_pkg::*;
#(
    parameter int SWAP = 0
)(
    input  wire logic              clk,
    input  wire logic              reset,
    audio_mix_sequencer_if.slave   bus
);

    mix_state_t r_state;
    mix_state_t w_next;

    logic signed [DW-1:0]    r_aud [4];
    logic        [VW-1:0]    r_vol [4];
    logic signed [ACC_W-1:0] w_acc_l;
    logic signed [ACC_W-1:0] w_acc_r;

    logic       w_tick;
    logic       w_snap;
    logic       w_mac_en;
    logic       w_load;
    logic [1:0] w_ch;
    logic       w_to_left;
    logic       w_unused;

    assign w_tick = bus.clk7_en & bus.cck;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_next = ST_CH0;
            ST_CH0:  w_next = ST_CH1;
            ST_CH1:  w_next = ST_CH2;
            ST_CH2:  w_next = ST_CH3;
            ST_CH3:  w_next = ST_LOAD;
            ST_LOAD: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- control outputs ----------------
    always_comb begin
        w_snap   = 1'b0;
        w_mac_en = 1'b0;
        w_load   = 1'b0;
        w_ch     = 2'd0;
        case (r_state)
            ST_IDLE: w_snap = w_tick;
            ST_CH0:  begin w_mac_en = 1'b1; w_ch = 2'd0; end
            ST_CH1:  begin w_mac_en = 1'b1; w_ch = 2'd1; end
            ST_CH2:  begin w_mac_en = 1'b1; w_ch = 2'd2; end
            ST_CH3:  begin w_mac_en = 1'b1; w_ch = 2'd3; end
            ST_LOAD: w_load = 1'b1;
            default: ;
        endcase
    end

    assign w_to_left = CH_LEFT_MAP[w_ch] ^ (SWAP != 0);

    // Snapshot decouples the sequence from input changes after the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_aud[i] <= '0;
                r_vol[i] <= '0;
            end
        end else if (w_snap) begin
            r_aud[0] <= bus.aud0;  r_vol[0] <= bus.vol0;
            r_aud[1] <= bus.aud1;  r_vol[1] <= bus.vol1;
            r_aud[2] <= bus.aud2;  r_vol[2] <= bus.vol2;
            r_aud[3] <= bus.aud3;  r_vol[3] <= bus.vol3;
        end
    end

    audio_mix_sequencer_vol_mac u_mac (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_snap),
        .i_en      (w_mac_en),
        .i_to_left (w_to_left),
        .i_sample  (r_aud[w_ch]),
        .i_vol     (r_vol[w_ch]),
        .o_acc_l   (w_acc_l),
        .o_acc_r   (w_acc_r)
    );

    // Sum of two products spans -16384..16256, so bits [14:6] hold the
    // floor-divided result without overflow; the rest is not needed.
    assign w_unused = &{1'b0, w_acc_l[ACC_W-1], w_acc_l[SHIFT-1:0],
                              w_acc_r[ACC_W-1], w_acc_r[SHIFT-1:0]};

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ldatasum     <= '0;
            bus.rdatasum     <= '0;
            bus.sample_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.sample_valid <= w_load;
            bus.busy         <= (w_next != ST_IDLE);
            bus.overrun      <= w_tick && (r_state != ST_IDLE);
            if (w_load) begin
                if (bus.mute) begin
                    bus.ldatasum <= '0;
                    bus.rdatasum <= '0;
                end else begin
                    bus.ldatasum <= w_acc_l[SHIFT+OW-1:SHIFT];
                    bus.rdatasum <= w_acc_r[SHIFT+OW-1:SHIFT];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_audio_mix_sequencer
// Description: Directed self-checking bench for audio_mix_sequencer. Two
//              instances (SWAP=0 and SWAP=1) receive identical stimulus.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_audio_mix_sequencer;
    import audio_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    audio_mix_sequencer_if bus0 ();
    audio_mix_sequencer_if bus1 ();

    // Swapped instance mirrors the inputs of the main one.
    assign bus1.clk7_en = bus0.clk7_en;
    assign bus1.cck     = bus0.cck;
    assign bus1.aud0    = bus0.aud0;
    assign bus1.aud1    = bus0.aud1;
    assign bus1.aud2    = bus0.aud2;
    assign bus1.aud3    = bus0.aud3;
    assign bus1.vol0    = bus0.vol0;
    assign bus1.vol1    = bus0.vol1;
    assign bus1.vol2    = bus0.vol2;
    assign bus1.vol3    = bus0.vol3;
    assign bus1.mute    = bus0.mute;

    audio_mix_sequencer #(.SWAP(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    audio_mix_sequencer #(.SWAP(1)) u_dut_swap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic signed [7:0] a0, a1, a2, a3,
                              input logic [6:0] v0, v1, v2, v3);
        bus0.aud0 = a0; bus0.aud1 = a1; bus0.aud2 = a2; bus0.aud3 = a3;
        bus0.vol0 = v0; bus0.vol1 = v1; bus0.vol2 = v2; bus0.vol3 = v3;
    endtask

    task automatic tick_on();
        bus0.clk7_en = 1'b1;
        bus0.cck     = 1'b1;
    endtask

    task automatic tick_off();
        bus0.clk7_en = 1'b0;
        bus0.cck     = 1'b0;
    endtask

    // Pulses tick for one edge (E0) and returns the number of edges until
    // sample_valid is seen, or -1 if it never arrives within 20 clocks.
    task automatic fire_tick(output int lat);
        @(posedge clk); #1 tick_on();
        @(posedge clk); #1 tick_off();
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.sample_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_off();
        bus0.mute = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus0.ldatasum, bus0.rdatasum, bus0.sample_valid, bus0.busy, bus0.overrun} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_state: got l=%h r=%h v=%b b=%b o=%b, want all 0",
                     bus0.ldatasum, bus0.rdatasum, bus0.sample_valid, bus0.busy, bus0.overrun);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_no_tick();
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1 bus0.clk7_en = 1'b1; bus0.cck = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (bus0.busy !== 1'b0) seen = 1'b1;
        end
        #1 tick_off();
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL no_tick_busy: busy went %b, want 0 without cck", seen);
        end
    endtask

    task automatic test_single();
        int lat;
        set_inputs(127, 0, 0, 0, 64, 0, 0, 0);
        fire_tick(lat);
        n_vec++;
        if (lat !== 5) begin
            n_err++; $display("FAIL single_latency: got %0d want 5", lat);
        end
        n_vec++;
        if (bus0.ldatasum !== 9'h07F || bus0.rdatasum !== 9'h000) begin
            n_err++; $display("FAIL single_sums: got l=%h r=%h want l=07f r=000",
                              bus0.ldatasum, bus0.rdatasum);
        end
        n_vec++;
        if (bus1.ldatasum !== 9'h000 || bus1.rdatasum !== 9'h07F) begin
            n_err++; $display("FAIL single_swap: got l=%h r=%h want l=000 r=07f",
                              bus1.ldatasum, bus1.rdatasum);
        end
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus0.sample_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.ldatasum !== 9'h07F) begin
            n_err++; $display("FAIL single_pulse_hold: got v=%b b=%b l=%h want v=0 b=0 l=07f",
                              bus0.sample_valid, bus0.busy, bus0.ldatasum);
        end
    endtask

    task automatic test_mix();
        int lat;
        set_inputs(-128, 127, 127, -128, 64, 64, 64, 64);
        fire_tick(lat);
        n_vec++;
        if (lat !== 5 || bus0.ldatasum !== 9'h100 || bus0.rdatasum !== 9'h0FE) begin
            n_err++; $display("FAIL mix_extremes: got lat=%0d l=%h r=%h want 5 l=100 r=0fe",
                              lat, bus0.ldatasum, bus0.rdatasum);
        end
        n_vec++;
        if (bus1.ldatasum !== 9'h0FE || bus1.rdatasum !== 9'h100) begin
            n_err++; $display("FAIL mix_swap: got l=%h r=%h want l=0fe r=100",
                              bus1.ldatasum, bus1.rdatasum);
        end
    endtask

    task automatic test_clamp();
        logic signed [7:0] a_tab [4] = '{8'sd100, -8'sd1, 8'sd1, 8'sd64};
        logic [6:0]        v_tab [4] = '{7'd127, 7'd1, 7'd1, 7'd63};
        logic [8:0]        r_tab [4] = '{9'h064, 9'h1FF, 9'h000, 9'h03F};
        int lat;
        for (int i = 0; i < 4; i++) begin
            set_inputs(0, a_tab[i], 0, 0, 0, v_tab[i], 0, 0);
            fire_tick(lat);
            n_vec++;
            if (lat !== 5 || bus0.rdatasum !== r_tab[i] || bus0.ldatasum !== 9'h000) begin
                n_err++; $display("FAIL clamp_round[%0d]: got lat=%0d l=%h r=%h want 5 l=000 r=%h",
                                  i, lat, bus0.ldatasum, bus0.rdatasum, r_tab[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int lat;
        set_inputs(127, 0, 0, 0, 64, 0, 0, 0);
        @(posedge clk); #1 tick_on();
        @(posedge clk); #1 tick_off();      // E0
        bus0.aud0 = -8'sd128;
        @(posedge clk); #1 tick_on();       // E1
        @(posedge clk); #1 tick_off();      // E2: dropped tick
        @(negedge clk);
        n_vec++;
        if (bus0.overrun !== 1'b1 || bus0.busy !== 1'b1) begin
            n_err++; $display("FAIL overrun_pulse: got o=%b b=%b want o=1 b=1",
                              bus0.overrun, bus0.busy);
        end
        @(posedge clk); @(negedge clk);     // E3
        n_vec++;
        if (bus0.overrun !== 1'b0) begin
            n_err++; $display("FAIL overrun_single: got o=%b want 0", bus0.overrun);
        end
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus0.sample_valid === 1'b1) begin lat = k; break; end
        end
        n_vec++;
        if (lat !== 2 || bus0.ldatasum !== 9'h07F || bus0.rdatasum !== 9'h000) begin
            n_err++; $display("FAIL overrun_snapshot: got lat=%0d l=%h r=%h want 2 l=07f r=000",
                              lat, bus0.ldatasum, bus0.rdatasum);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus0.busy !== 1'b0) begin
            n_err++; $display("FAIL overrun_no_restart: got busy=%b want 0", bus0.busy);
        end
    endtask

    task automatic test_overrun_load();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 tick_on();
        @(posedge clk); #1 tick_off();      // E0
        repeat (4) @(posedge clk);          // E1..E4, now in LOAD
        #1 tick_on();
        @(posedge clk); #1 tick_off();      // E5
        @(negedge clk);
        n_vec++;
        if (bus0.sample_valid !== 1'b1 || bus0.overrun !== 1'b1) begin
            n_err++; $display("FAIL load_overrun: got v=%b o=%b want v=1 o=1",
                              bus0.sample_valid, bus0.overrun);
        end
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (bus0.busy !== 1'b0 || bus0.overrun !== 1'b0) begin
            n_err++; $display("FAIL load_overrun_after: got b=%b o=%b want b=0 o=0",
                              bus0.busy, bus0.overrun);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic seen;
        set_inputs(127, 0, 0, 0, 64, 0, 0, 0);
        fire_tick(lat);                     // outputs now nonzero
        @(posedge clk); #1 tick_on();
        @(posedge clk); #1 tick_off();      // E0
        @(posedge clk);                     // E1
        @(posedge clk); #1 reset = 1'b1;    // E2, in CH2 next
        @(posedge clk); #1 reset = 1'b0;    // E3 sampled reset
        @(negedge clk);
        n_vec++;
        if ({bus0.ldatasum, bus0.rdatasum, bus0.sample_valid, bus0.busy, bus0.overrun} !== 21'd0) begin
            n_err++; $display("FAIL reset_mid: got l=%h r=%h v=%b b=%b o=%b want all 0",
                              bus0.ldatasum, bus0.rdatasum, bus0.sample_valid, bus0.busy, bus0.overrun);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (bus0.sample_valid !== 1'b0 || bus0.busy !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_abandon: activity seen=%b want 0", seen);
        end
        set_inputs(127, 100, 0, 0, 64, 64, 0, 0);
        fire_tick(lat);
        n_vec++;
        if (lat !== 5 || bus0.ldatasum !== 9'h07F || bus0.rdatasum !== 9'h064) begin
            n_err++; $display("FAIL reset_mid_recover: got lat=%0d l=%h r=%h want 5 l=07f r=064",
                              lat, bus0.ldatasum, bus0.rdatasum);
        end
    endtask

    task automatic test_mute();
        int lat;
        set_inputs(127, 0, 0, 0, 64, 0, 0, 0);
        bus0.mute = 1'b1;
        fire_tick(lat);
        n_vec++;
        if (lat !== 5 || bus0.ldatasum !== 9'h000 || bus0.rdatasum !== 9'h000) begin
            n_err++; $display("FAIL mute: got lat=%0d l=%h r=%h want 5 l=000 r=000",
                              lat, bus0.ldatasum, bus0.rdatasum);
        end
        bus0.mute = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_no_tick();
        test_single();
        test_mix();
        test_clamp();
        test_overrun();
        test_overrun_load();
        test_reset_mid();
        test_mute();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
